seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Output stage directly downstream of the TSC CPU core. Takes the 16-bit register/WWD value and the low 8 bits of the PC, snapshots them once per display frame, and drives a 4-digit multiplexed common-anode hex 7-segment display plus 8 PC LEDs on the FPGA board. Snapshotting only at frame boundaries prevents digit tearing while the CPU runs.

## Interface
- SCAN_DIV, 50000: clock cycles per digit slot; legal range is 1 or more.
- clk  in  1  system clock, same as the CPU.
- reset_n  in  1  asynchronous, active-low reset.
- output_port  in  16  value from the CPU (WWD or selected register).
- PC_below8bit  in  8  low 8 bits of the CPU PC.
- hold  in  1  freeze; 1 = skip snapshot updates. Synchronous to clk.
- an  out  4  digit anodes, active-low; an[0] is the least-significant nibble.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- led  out  8  PC LEDs, active-high.
- All outputs are registered.
- Clock and reset (already decided): one clock `clk`; reset `reset_n` is asynchronous and active-low.

## Operation
- **Prescaler.** `div_cnt` counts 0 to SCAN_DIV-1, then wraps to 0. `tick` is true when `div_cnt == SCAN_DIV-1`. When SCAN_DIV=1, `tick` is true every cycle.
- **Digit index.** `idx` is 2 bits. On each tick the outputs are loaded for the current `idx`, then `idx` increments mod 4. Four ticks make one frame.
- **Snapshot.** On a tick with `idx==3` and `hold==0`:
  - `snap` ← output_port
  - `led` ← PC_below8bit
  - `chg` ← (output_port != `snap`)
- When `hold==1` on that tick, `snap`, `led` and `chg` are unchanged.
- **Digit load on tick:**
  - `an` = one-hot-low of `idx`.
  - `seg` = hex decode of `snap[4*idx+3 : 4*idx]`.
  - `dp` = 0 only when `idx==0` and `chg==1`; otherwise 1.
- **Hex decode (active-low, {g..a}).** 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- **Reset values:** an=1111, seg=1111111, dp=1, led=00000000, snap=0000, chg=0, idx=0, div_cnt=0.
- **Reset mid-frame:** all state clears immediately (asynchronously). Scanning restarts from digit 0.

## Timing
- After reset_n rises, the first tick occurs at clock edge SCAN_DIV and lights digit 0, showing 0.
- The first frame always shows 0000, because the snapshot is taken at the end of that frame.
- Input-to-display latency: a value present at the `idx==3` tick appears on digit 0 at the next tick, SCAN_DIV cycles later. Digits 1–3 follow one tick apart.
- Inputs are sampled only on snapshot ticks. Changes between snapshot ticks are never displayed.
- `led` and `snap` update at the same edge.
- `chg` holds for one full frame (four ticks).
- `hold` asserted and released within one frame, without covering a snapshot tick, has no effect.
- Outputs change only on tick edges or on reset.

## Configuration
- Macro: `SEG_SCAN_BLANK_EN`.
- **Defined:** leading-zero blanking. A digit with `idx>0` is blanked when its nibble and every higher nibble of `snap` are 0.
  - A blanked slot drives an=1111, seg=1111111 and dp=1 for its tick.
  - Digit 0 is never blanked.
- **Undefined:** all four digits are always driven as described under Operation.

## Test plan
- **Reset and first tick.** SCAN_DIV=4, hold reset_n low, then release. Required:
  - During reset: an=1111, seg=1111111, led=00.
  - At edge 4: an=1110, seg=1000000.
- **Scan order and snapshot.** output_port=16'h1A3F, PC_below8bit=8'h2C.
  - After the first frame: led=2C.
  - Next frame: digits 0..3 show seg F=0001110, 3=0110000, A=0001000, 1=1111001, with an=1110, 1101, 1011, 0111 in that order.
- **Change indicator.**
  - Repeat 16'h1A3F for a second snapshot: dp=1 on digit 0.
  - Then 16'h1A40: dp=0 on digit 0 for one frame, and dp=1 on digits 1–3.
- **Hold.** Set hold=1 across the snapshot tick and change output_port to 16'h0005. Required: the display still shows 1A3F, led is unchanged, and chg=0.
- **Blanking** (SEG_SCAN_BLANK_EN defined). snap=16'h0005.
  - Digits 1–3: an=1111, seg=1111111.
  - Digit 0 shows 5.
  - snap=16'h0000: digit 0 shows 0.
  - Without the macro, 16'h0005 shows 0,0,0,5.
- **Mid-frame reset.** Assert reset_n low at idx=2.
  - Outputs return to reset values within the same cycle (asynchronous reset).
  - After release, the first tick is at edge SCAN_DIV on digit 0.

Source files
------------

// File: rtl/seg_scan_display.sv
// Frame-synchronous 4-digit hex 7-segment scanner with PC LEDs for the TSC CPU board.
// Optional leading-zero blanking is enabled by defining SEG_SCAN_BLANK_EN.
module seg_scan_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] output_port,
    input  logic [7:0]  PC_below8bit,
    input  logic        hold,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [7:0]  led
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DIV_ONE  = CW'(1);

    logic [CW-1:0] r_div_cnt;
    logic [1:0]    r_idx;
    logic [15:0]   r_snap;
    logic          r_chg;
    logic          w_tick;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic [3:0]    w_an;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign w_tick = (r_div_cnt == DIV_LAST);
    assign w_an   = ~(4'b0001 << r_idx);

    // Select the nibble shown in the current digit slot.
    always_comb begin
        w_nib = 4'h0;
        case (r_idx)
            2'd0:    w_nib = r_snap[3:0];
            2'd1:    w_nib = r_snap[7:4];
            2'd2:    w_nib = r_snap[11:8];
            2'd3:    w_nib = r_snap[15:12];
            default: w_nib = 4'h0;
        endcase
    end

`ifdef SEG_SCAN_BLANK_EN
    // A digit is blank when it and every higher nibble are zero; digit 0 always shows.
    always_comb begin
        w_blank = 1'b0;
        case (r_idx)
            2'd0:    w_blank = 1'b0;
            2'd1:    w_blank = (r_snap[15:4] == 12'h000);
            2'd2:    w_blank = (r_snap[15:8] == 8'h00);
            2'd3:    w_blank = (r_snap[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    // Blanking disabled: every digit is driven.
    always_comb begin
        w_blank = 1'b0;
    end
`endif

    // Prescaler producing one tick per digit slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_ONE;
        end
    end

    // Digit load, scan advance and end-of-frame snapshot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx  <= 2'd0;
            r_snap <= 16'h0000;
            r_chg  <= 1'b0;
            an     <= 4'b1111;
            seg    <= 7'b1111111;
            dp     <= 1'b1;
            led    <= 8'h00;
        end else if (w_tick) begin
            r_idx <= r_idx + 2'd1;
            if (w_blank) begin
                an  <= 4'b1111;
                seg <= 7'b1111111;
                dp  <= 1'b1;
            end else begin
                an  <= w_an;
                seg <= hex_to_seg(w_nib);
                dp  <= ~((r_idx == 2'd0) && r_chg);
            end
            // Snapshot taken after digit 3 is loaded so the whole next frame is consistent.
            if ((r_idx == 2'd3) && !hold) begin
                r_snap <= output_port;
                led    <= PC_below8bit;
                r_chg  <= (output_port != r_snap);
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: cycle-count reference model, directed and random phases.
module tb_seg_scan_display;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] output_port = 16'h0000;
    logic [7:0]  PC_below8bit = 8'h00;
    logic        hold = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  led;

    int total = 0;
    int bad = 0;

    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seg_scan_display #(.SCAN_DIV(DIV)) dut (
        .clk(clk), .reset_n(reset_n), .output_port(output_port),
        .PC_below8bit(PC_below8bit), .hold(hold),
        .an(an), .seg(seg), .dp(dp), .led(led)
    );

    always #5 clk = ~clk;

    // Reference model: edges since reset release, tick on every DIV-th edge.
    int          cyc = 0;
    logic [15:0] m_snap = 16'h0000;
    logic        m_chg = 1'b0;
    logic [3:0]  e_an = 4'b1111;
    logic [6:0]  e_seg = 7'b1111111;
    logic        e_dp = 1'b1;
    logic [7:0]  e_led = 8'h00;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0; m_snap = 16'h0000; m_chg = 1'b0;
            e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_led = 8'h00;
        end else begin
            cyc = cyc + 1;
            if (cyc % DIV == 0) begin
                int d;
                logic blank;
                logic [3:0] one;
                d = ((cyc / DIV) - 1) % 4;
                one = 4'b0001;
                blank = 1'b0;
`ifdef SEG_SCAN_BLANK_EN
                blank = (d > 0) && ((m_snap >> (4 * d)) == 16'h0000);
`endif
                if (blank) begin
                    e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
                end else begin
                    e_an = ~(one << d);
                    e_seg = HEX[(m_snap >> (4 * d)) & 16'h000F];
                    e_dp = !(d == 0 && m_chg);
                end
                if (d == 3 && !hold) begin
                    m_chg = (output_port != m_snap);
                    m_snap = output_port;
                    e_led = PC_below8bit;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        total = total + 1;
        if (an !== e_an || seg !== e_seg || dp !== e_dp || led !== e_led) begin
            bad = bad + 1;
            $display("FAIL model cyc=%0d an=%b/%b seg=%b/%b dp=%b/%b led=%h/%h (got/exp)",
                     cyc, an, e_an, seg, e_seg, dp, e_dp, led, e_led);
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic go_to(input int k);
        int guard;
        guard = 0;
        while (cyc < k && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (cyc != k) chk("go_to_bound", 16'(cyc), 16'(k));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_led", {8'h0, led}, 16'h0000);
        output_port = 16'h1A3F;
        PC_below8bit = 8'h2C;
        reset_n = 1'b1;

        go_to(4);
        chk("first_an", {12'h0, an}, 16'h000E);
        chk("first_seg", {9'h0, seg}, 16'h0040);
        go_to(16);
        chk("led_2c", {8'h0, led}, 16'h002C);
        go_to(20);
        chk("d0_an", {12'h0, an}, 16'h000E);
        chk("d0_seg_F", {9'h0, seg}, 16'h000E);
        chk("d0_dp_chg", {15'h0, dp}, 16'h0000);
        go_to(24);
        chk("d1_an", {12'h0, an}, 16'h000D);
        chk("d1_seg_3", {9'h0, seg}, 16'h0030);
        go_to(28);
        chk("d2_an", {12'h0, an}, 16'h000B);
        chk("d2_seg_A", {9'h0, seg}, 16'h0008);
        go_to(32);
        chk("d3_an", {12'h0, an}, 16'h0007);
        chk("d3_seg_1", {9'h0, seg}, 16'h0079);
        go_to(36);
        chk("repeat_dp", {15'h0, dp}, 16'h0001);

        hold = 1'b1;
        output_port = 16'h0005;
        PC_below8bit = 8'h77;
        go_to(48);
        hold = 1'b0;
        output_port = 16'h1A40;
        go_to(52);
        chk("hold_seg", {9'h0, seg}, 16'h000E);
        chk("hold_dp", {15'h0, dp}, 16'h0001);
        chk("hold_led", {8'h0, led}, 16'h002C);
        go_to(68);
        chk("chg_dp", {15'h0, dp}, 16'h0000);
        chk("chg_seg0", {9'h0, seg}, 16'h0040);
        chk("chg_led", {8'h0, led}, 16'h0077);
        go_to(72);
        chk("chg_dp1", {15'h0, dp}, 16'h0001);
        chk("chg_seg4", {9'h0, seg}, 16'h0019);

        output_port = 16'h0005;
        go_to(84);
        chk("five_d0", {9'h0, seg}, 16'h0012);
        output_port = 16'h0000;
        go_to(88);
`ifdef SEG_SCAN_BLANK_EN
        chk("blank_an", {12'h0, an}, 16'h000F);
        chk("blank_seg", {9'h0, seg}, 16'h007F);
`else
        chk("noblank_an", {12'h0, an}, 16'h000D);
        chk("noblank_seg", {9'h0, seg}, 16'h0040);
`endif
        go_to(100);
        chk("zero_d0_an", {12'h0, an}, 16'h000E);
        chk("zero_d0_seg", {9'h0, seg}, 16'h0040);

        output_port = 16'hBEEF;
        go_to(108);
        chk("pre_rst_an", {12'h0, an}, 16'h000B);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_an", {12'h0, an}, 16'h000F);
        chk("mid_rst_seg", {9'h0, seg}, 16'h007F);
        chk("mid_rst_dp", {15'h0, dp}, 16'h0001);
        chk("mid_rst_led", {8'h0, led}, 16'h0000);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        go_to(3);
        chk("post_rst_quiet", {12'h0, an}, 16'h000F);
        go_to(4);
        chk("post_rst_an", {12'h0, an}, 16'h000E);
        chk("post_rst_seg", {9'h0, seg}, 16'h0040);

        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: output_port = 16'($urandom);
                    1: output_port = 16'($urandom) & 16'h000F;
                    2: output_port = 16'($urandom) & 16'h00FF;
                    default: output_port = 16'h0000;
                endcase
            end
            PC_below8bit = 8'($urandom);
            hold = ($urandom_range(0, 3) == 0);
        end
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
